generic_single_port_sync_ram_be: RTL and testbench
==================================================

GENERIC_SINGLE_PORT_SYNC_RAM_BE -- requirements
Module: generic_single_port_sync_ram_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, word-address width; depth = 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter LANE_WIDTH, default 8, bits per byte lane.
REQ-003 SHALL have parameter NUM_LANES, default 4, lanes per word; DATA_WIDTH = NUM_LANES*LANE_WIDTH.
REQ-004 SHALL have parameter WRITE_FIRST, default 0; 0 = read-first, 1 = write-first on same-address read-during-write.
REQ-005 SHALL have parameter OUTPUT_REG, default 0; 1 adds one output pipeline register.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = hardware clear sweep after reset.
REQ-007 SHALL have parameter CLEAR_VALUE, default 0, LANE_WIDTH-bit fill value written to every lane.
REQ-008 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-009 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port req_i, input, 1, access request, sampled only while ready_o=1.
REQ-011 SHALL have port we_i, input, 1, 1 = write, 0 = read.
REQ-012 SHALL have port sel_i, input, NUM_LANES, per-lane write enable; lane k = data bits [(k+1)*LANE_WIDTH-1 : k*LANE_WIDTH].
REQ-013 SHALL have port addr_i, input, ADDR_WIDTH, word address.
REQ-014 SHALL have port data_i, input, DATA_WIDTH, write data.
REQ-015 SHALL have port clear_i, input, 1, one-cycle pulse to start a clear sweep.
REQ-016 SHALL have port data_o, output, DATA_WIDTH, read data.
REQ-017 SHALL have port valid_o, output, 1, one-cycle pulse qualifying data_o.
REQ-018 SHALL have port ready_o, output, 1, 1 = accepting requests (not clearing).

Function
REQ-019 SHALL implement FSM states RUN and CLEAR; RUN drives ready_o=1, CLEAR drives ready_o=0.
REQ-020 In CLEAR, SHALL write CLEAR_VALUE to all lanes of one word per cycle, ascending from address 0; after the write to 2^ADDR_WIDTH-1 it SHALL enter RUN the next cycle. A sweep therefore takes exactly 2^ADDR_WIDTH cycles.
REQ-021 The clear address counter SHALL be ADDR_WIDTH+1 bits wide, with termination detected on the MSB and no wrap to 0.
REQ-022 clear_i=1 in RUN SHALL enter CLEAR the next cycle, restarting at address 0; clear_i in CLEAR SHALL be ignored.
REQ-023 When clear_i and req_i are both 1 in RUN, the request SHALL be accepted in that cycle and the clear SHALL start the next cycle.
REQ-024 A read (req_i=1, we_i=0, ready_o=1) SHALL present data on data_o with valid_o=1 exactly 1+OUTPUT_REG cycles after acceptance.
REQ-025 data_o SHALL hold its last value while valid_o=0.
REQ-026 A write (req_i=1, we_i=1) SHALL update only the lanes with sel_i[k]=1, and SHALL NOT pulse valid_o; sel_i=0 SHALL be a no-op.
REQ-027 Back-to-back accepted requests SHALL sustain one per cycle with no bubbles.
REQ-028 Requests with ready_o=0 SHALL be dropped, with no memory change and no valid_o.
REQ-029 Read pulses already in the output pipeline when CLEAR starts SHALL still complete, carrying pre-clear data.
REQ-030 Memory contents SHALL be undefined after power-up when CLEAR_ON_RESET=0.

Reset
REQ-031 rst_i=1 SHALL asynchronously force data_o=0, valid_o=0, the pipeline registers to 0, and the clear counter to 0.
REQ-032 During reset, ready_o SHALL be 0 when CLEAR_ON_RESET=1 and 1 otherwise.
REQ-033 On reset release, the FSM SHALL start in CLEAR when CLEAR_ON_RESET=1, else in RUN.
REQ-034 Reset asserted mid-sweep SHALL abort the sweep; on release the sweep SHALL restart from address 0.
REQ-035 Reset SHALL NOT alter memory contents; the array SHALL have no reset so it infers block RAM.

Structure
REQ-036 FSM state encodings and the WRITE_FIRST/READ_FIRST mode constants SHALL live in the shared memory package.
REQ-037 Each lane SHALL be a sub-module generic_ram_lane (ADDR_WIDTH, LANE_WIDTH, WRITE_FIRST), instantiated NUM_LANES times.

Verification
REQ-038 Sweep and timing: defaults, reset release -> ready_o=0 for exactly 2048 cycles; then reads of addresses 0, 1000 and 2047 -> 0x00000000.
REQ-039 Byte-lane write: write 0xAABBCCDD with sel=4'b1111, then 0x11223344 with sel=4'b0101 at address 5; read -> 0xAA22CC44 with valid_o one cycle after the read (two cycles with OUTPUT_REG=1).
REQ-040 Read-during-write: mem[3]=0x0 and req read+write 0xFFFFFFFF, sel=1111 at address 3 -> data_o=0x0 when WRITE_FIRST=0, 0xFFFFFFFF when WRITE_FIRST=1.
REQ-041 Clear during traffic: clear_i with a simultaneous read at address 7 holding 0x12345678 -> valid_o returns 0x12345678, ready_o drops the next cycle, and address 7 reads 0x0 after the sweep.
REQ-042 Reset mid-sweep: assert rst_i at sweep address 100 for 2 cycles -> outputs are zero and the sweep restarts; ready_o rises exactly 2048 cycles after release.
REQ-043 Blocked request: req_i writes while ready_o=0 -> no memory change and no valid_o.

Source files
------------

// File: rtl/generic_single_port_sync_ram_be_pkg.sv
// Shared definitions for the byte-enable single-port RAM: sweep FSM states,
// read-during-write mode constants and small helpers.
package generic_single_port_sync_ram_be_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } ram_state_e;

  localparam int MODE_READ_FIRST  = 0;
  localparam int MODE_WRITE_FIRST = 1;

  function automatic logic is_write_first(input int mode);
    return (mode == MODE_WRITE_FIRST);
  endfunction

  // State the FSM leaves reset in, depending on whether a clear sweep follows.
  function automatic ram_state_e reset_state(input int clear_on_reset);
    return (clear_on_reset != 0) ? ST_CLEAR : ST_RUN;
  endfunction

endpackage

// File: rtl/generic_single_port_sync_ram_be_lane.sv
// One byte lane of the RAM: a synchronous single-port array with a registered
// read port whose same-address behaviour is chosen by WRITE_FIRST.
module generic_ram_lane
  import generic_single_port_sync_ram_be_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int LANE_WIDTH  = 8,
  parameter int WRITE_FIRST = 0
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LANE_WIDTH-1:0] wdata_i,
  output logic [LANE_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // No reset on the array or read register so the lane maps onto block RAM.
  logic [LANE_WIDTH-1:0] mem_r [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_r[addr_i] <= wdata_i;
      end
      if (we_i && is_write_first(WRITE_FIRST)) begin
        rdata_o <= wdata_i;
      end else begin
        rdata_o <= mem_r[addr_i];
      end
    end
  end

endmodule

// File: rtl/generic_single_port_sync_ram_be.sv
// Single-port synchronous RAM with per-lane write enables, optional output
// register and a hardware clear sweep after reset or on request.
module generic_single_port_sync_ram_be
  import generic_single_port_sync_ram_be_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 11,
  parameter int                    LANE_WIDTH     = 8,
  parameter int                    NUM_LANES      = 4,
  parameter int                    WRITE_FIRST    = MODE_READ_FIRST,
  parameter int                    OUTPUT_REG     = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [LANE_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_i,
  input  logic                            we_i,
  input  logic [NUM_LANES-1:0]            sel_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] data_i,
  input  logic                            clear_i,
  output logic [NUM_LANES*LANE_WIDTH-1:0] data_o,
  output logic                            valid_o,
  output logic                            ready_o
);

  localparam int DATA_WIDTH = NUM_LANES * LANE_WIDTH;

  ram_state_e              state_r;
  logic                    ready_r;
  logic [ADDR_WIDTH:0]     clr_cnt_r;
  logic [ADDR_WIDTH:0]     clr_cnt_nxt_s;
  logic                    accept_s;
  logic                    rd_valid_r;
  logic                    lane_en_s;
  logic [NUM_LANES-1:0]    lane_we_s;
  logic [ADDR_WIDTH-1:0]   lane_addr_s;
  logic [DATA_WIDTH-1:0]   lane_wdata_s;
  logic [DATA_WIDTH-1:0]   lane_q_s;

  assign accept_s      = req_i & ready_r;
  assign clr_cnt_nxt_s = clr_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign ready_o       = ready_r;

  // Sweep FSM; the counter's extra MSB flags the write to the last word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= reset_state(CLEAR_ON_RESET);
      ready_r   <= (CLEAR_ON_RESET == 0);
      clr_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (clear_i) begin
            state_r   <= ST_CLEAR;
            ready_r   <= 1'b0;
            clr_cnt_r <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_r <= clr_cnt_nxt_s;
          if (clr_cnt_nxt_s[ADDR_WIDTH]) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_RUN;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Lane port steering: the sweep owns the port while clearing.
  always_comb begin
    lane_en_s    = 1'b0;
    lane_we_s    = '0;
    lane_addr_s  = addr_i;
    lane_wdata_s = data_i;
    if (state_r == ST_CLEAR) begin
      lane_en_s    = 1'b1;
      lane_we_s    = '1;
      lane_addr_s  = clr_cnt_r[ADDR_WIDTH-1:0];
      lane_wdata_s = {NUM_LANES{CLEAR_VALUE}};
    end else begin
      lane_en_s = accept_s;
      if (accept_s && we_i) begin
        lane_we_s = sel_i;
      end else begin
        lane_we_s = '0;
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    generic_ram_lane #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .LANE_WIDTH  (LANE_WIDTH),
      .WRITE_FIRST (WRITE_FIRST)
    ) u_lane (
      .clk_i   (clk_i),
      .en_i    (lane_en_s),
      .we_i    (lane_we_s[k]),
      .addr_i  (lane_addr_s),
      .wdata_i (lane_wdata_s[k*LANE_WIDTH +: LANE_WIDTH]),
      .rdata_o (lane_q_s[k*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  // Marks the cycle in which lane_q_s holds an accepted read's data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= accept_s & ~we_i;
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;

    // Extra output stage; captures lane data only on a read pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        data_r  <= '0;
        valid_r <= 1'b0;
      end else begin
        valid_r <= rd_valid_r;
        if (rd_valid_r) begin
          data_r <= lane_q_s;
        end
      end
    end

    assign data_o  = data_r;
    assign valid_o = valid_r;
  end else begin : g_ocomb
    logic [DATA_WIDTH-1:0] hold_r;

    // The lane register changes on writes and sweeps, so keep the last read.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hold_r <= '0;
      end else if (rd_valid_r) begin
        hold_r <= lane_q_s;
      end
    end

    assign data_o  = rd_valid_r ? lane_q_s : hold_r;
    assign valid_o = rd_valid_r;
  end

endmodule

// File: tb/tb_generic_single_port_sync_ram_be.sv
// Bench: default-parameter RAM checked with vector tables, corner sequences and
// a random word/lane model, plus a small write-first/output-register instance.
module tb_generic_single_port_sync_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, clr;
  logic [3:0]  sel;
  logic [10:0] addr;
  logic [31:0] din, dout;
  logic        valid, ready;

  logic        req2, we2, clr2;
  logic [3:0]  sel2;
  logic [3:0]  addr2;
  logic [31:0] din2, dout2;
  logic        valid2, ready2;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_m [0:2047];
  logic [31:0] held;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [10:0] addr;
    logic [31:0] data;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [0:9];

  always #5 clk = ~clk;

  generic_single_port_sync_ram_be dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .sel_i(sel),
    .addr_i(addr), .data_i(din), .clear_i(clr),
    .data_o(dout), .valid_o(valid), .ready_o(ready)
  );

  generic_single_port_sync_ram_be #(
    .ADDR_WIDTH(4), .WRITE_FIRST(1), .OUTPUT_REG(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h5A)
  ) d2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .we_i(we2), .sel_i(sel2),
    .addr_i(addr2), .data_i(din2), .clear_i(clr2),
    .data_o(dout2), .valid_o(valid2), .ready_o(ready2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < 4; k++) if (s[k]) m[k*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Waits for ready while poking blocked writes/reads and a stray clear pulse.
  task automatic wait_ready(output int n, output int vseen, output int n2);
    n = 0; vseen = 0; n2 = 0;
    while (ready == 1'b0 && n < 5000) begin
      if (ready2 == 1'b0) n2++;
      req  = (n >= 10 && n < 40);
      we   = (n < 25);
      addr = 11'd9; din = 32'hDEADBEEF; sel = 4'hF;
      clr  = (n == 500);
      step();
      n++;
      if (valid) vseen++;
    end
    req = 1'b0; clr = 1'b0; we = 1'b0;
  endtask

  initial begin
    int n, vs, n2;
    int op;
    logic [10:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    rst = 1'b1; req = 1'b0; we = 1'b0; clr = 1'b0; sel = 4'h0; addr = 11'd0; din = 32'h0;
    req2 = 1'b0; we2 = 1'b0; clr2 = 1'b0; sel2 = 4'h0; addr2 = 4'd0; din2 = 32'h0;
    for (int i = 0; i < 2048; i++) mem_m[i] = 32'h0;

    step(); step();
    chk("rst_data", dout, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_ready2", {31'h0, ready2}, 32'h0);

    rst = 1'b0;
    wait_ready(n, vs, n2);
    chk("sweep_len", n, 2048);
    chk("sweep_no_valid", vs, 0);
    chk("sweep_len_d2", n2, 16);

    tbl[0] = '{1'b0, 4'h0, 11'd0,    32'h0,        1'b1, 32'h00000000};
    tbl[1] = '{1'b0, 4'h0, 11'd1000, 32'h0,        1'b1, 32'h00000000};
    tbl[2] = '{1'b0, 4'h0, 11'd2047, 32'h0,        1'b1, 32'h00000000};
    tbl[3] = '{1'b0, 4'h0, 11'd9,    32'h0,        1'b1, 32'h00000000};
    tbl[4] = '{1'b1, 4'hF, 11'd5,    32'hAABBCCDD, 1'b0, 32'h00000000};
    tbl[5] = '{1'b1, 4'h5, 11'd5,    32'h11223344, 1'b0, 32'h00000000};
    tbl[6] = '{1'b0, 4'h0, 11'd5,    32'h0,        1'b1, 32'hAA22CC44};
    tbl[7] = '{1'b1, 4'h0, 11'd5,    32'h55555555, 1'b0, 32'hAA22CC44};
    tbl[8] = '{1'b0, 4'h0, 11'd5,    32'h0,        1'b1, 32'hAA22CC44};
    tbl[9] = '{1'b1, 4'hF, 11'd3,    32'h00000000, 1'b0, 32'hAA22CC44};
    for (int i = 0; i < 10; i++) begin
      req = 1'b1; we = tbl[i].we; sel = tbl[i].sel; addr = tbl[i].addr; din = tbl[i].data;
      step();
      chk($sformatf("tbl%0d_valid", i), {31'h0, valid}, {31'h0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_data", i), dout, tbl[i].exp_data);
    end
    req = 1'b0;
    mem_m[5] = 32'hAA22CC44;

    // Same-address write in read-first mode: lane register sees old word.
    req = 1'b1; we = 1'b1; sel = 4'hF; addr = 11'd3; din = 32'hFFFFFFFF;
    step();
    chk("rdw_lane_q", dut.lane_q_s, 32'h0);
    chk("rdw_no_valid", {31'h0, valid}, 32'h0);
    we = 1'b0;
    step();
    chk("rdw_readback", dout, 32'hFFFFFFFF);
    mem_m[3] = 32'hFFFFFFFF;

    // Clear issued together with a read: the read still completes.
    we = 1'b1; addr = 11'd7; din = 32'h12345678;
    step();
    we = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; req = 1'b0;
    chk("clr_rd_valid", {31'h0, valid}, 32'h1);
    chk("clr_rd_data", dout, 32'h12345678);
    chk("clr_ready_drop", {31'h0, ready}, 32'h0);
    wait_ready(n, vs, n2);
    chk("clr_sweep_len", n, 2048);
    for (int i = 0; i < 2048; i++) mem_m[i] = 32'h0;
    req = 1'b1; we = 1'b0; addr = 11'd7;
    step();
    req = 1'b0;
    chk("clr_addr7", dout, 32'h0);
    addr = 11'd5; req = 1'b1;
    step();
    req = 1'b0;
    chk("clr_addr5", dout, 32'h0);

    // Reset in the middle of a sweep.
    req = 1'b1; we = 1'b1; sel = 4'hF; addr = 11'd200; din = 32'hCAFEBABE;
    step();
    we = 1'b0;
    step();
    req = 1'b0;
    chk("pre_rst_read", dout, 32'hCAFEBABE);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    #1;
    chk("rst_async_data", dout, 32'h0);
    step(); step();
    chk("midrst_valid", {31'h0, valid}, 32'h0);
    chk("midrst_ready", {31'h0, ready}, 32'h0);
    rst = 1'b0;
    wait_ready(n, vs, n2);
    chk("restart_sweep_len", n, 2048);
    req = 1'b1; we = 1'b0; addr = 11'd200;
    step();
    req = 1'b0;
    chk("restart_addr200", dout, 32'h0);
    held = 32'h0;

    // Random traffic against a word/lane model.
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom_range(0, 9) == 0) ? 11'd2047 : 11'($urandom_range(0, 15));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      req = (op != 0); we = (op == 2); addr = a; din = d; sel = s;
      if (op == 1) held = mem_m[a];
      if (op == 2) mem_m[a] = (mem_m[a] & ~lane_mask(s)) | (d & lane_mask(s));
      step();
      chk("rnd_valid", {31'h0, valid}, {31'h0, (op == 1)});
      chk("rnd_data", dout, held);
    end
    req = 1'b0;

    // Write-first instance with output register.
    req2 = 1'b1; we2 = 1'b0; addr2 = 4'd2;
    step();
    req2 = 1'b0;
    chk("d2_lat1_valid", {31'h0, valid2}, 32'h0);
    step();
    chk("d2_lat2_valid", {31'h0, valid2}, 32'h1);
    chk("d2_clear_value", dout2, 32'h5A5A5A5A);
    req2 = 1'b1; we2 = 1'b1; sel2 = 4'hF; addr2 = 4'd5; din2 = 32'hAABBCCDD;
    step();
    chk("d2_wf_full", d2.lane_q_s, 32'hAABBCCDD);
    sel2 = 4'h5; din2 = 32'h11223344;
    step();
    chk("d2_wf_partial", d2.lane_q_s, 32'hAA22CC44);
    we2 = 1'b0;
    step();
    req2 = 1'b0;
    chk("d2_no_early_valid", {31'h0, valid2}, 32'h0);
    step();
    chk("d2_read_valid", {31'h0, valid2}, 32'h1);
    chk("d2_read_data", dout2, 32'hAA22CC44);
    step();
    chk("d2_valid_drop", {31'h0, valid2}, 32'h0);
    chk("d2_data_hold", dout2, 32'hAA22CC44);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
